wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline's MEM/WB stage and the out-of-order-completing multiply/divide unit (MDU). It sits after the MEM/WB pipeline register and in front of the register file. MDU results wait in a one-entry holding buffer. Pipeline writes normally take priority. A starvation counter bounds how long an MDU result can wait: when the bound is reached, the block stalls the pipeline for one cycle and drains the buffer.

---
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the MEM/WB stage and the
// multiply/divide unit. MDU results park in a one-entry holding buffer and
// normally yield to pipeline writes. A starvation counter bounds the wait: once
// the buffered result has lost STARVE_MAX times in a row, the pipeline is
// stalled for one cycle and the buffer drains.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   pipe_we_i/rd_i/data_i        MEM/WB write request
//   mdu_valid_i/rd_i/data_i      MDU result (valid/ready handshake)
//   mdu_ready_o                  holding buffer empty and out of reset
//   stall_o                      combinational pipeline freeze for this cycle
//   rf_we_o/waddr_o/wdata_o      registered register-file write port

module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    output logic        stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic        hb_valid_q, hb_valid_d;
    logic [4:0]  hb_rd_q, hb_rd_d;
    logic [31:0] hb_data_q, hb_data_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic pipe_req;
    logic force_drain;
    logic hb_grant;
    logic pipe_grant;
    logic mdu_fire;

    // Writes to x0 are architecturally void, so they never compete for the port.
    assign pipe_req    = pipe_we_i & (pipe_rd_i != 5'd0);
    assign force_drain = hb_valid_q & (starve_cnt_q == StarveMax);
    assign hb_grant    = hb_valid_q & (~pipe_req | force_drain);
    assign pipe_grant  = pipe_req & ~force_drain;

    // Ready only when empty: load and drain can never share an edge.
    assign mdu_ready_o = rst_n & ~hb_valid_q;
    assign mdu_fire    = mdu_valid_i & mdu_ready_o;
    // Masked by reset so the pipeline is never frozen while the block is held.
    assign stall_o     = rst_n & force_drain & pipe_req;

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    always_comb begin
        hb_valid_d   = hb_valid_q;
        hb_rd_d      = hb_rd_q;
        hb_data_d    = hb_data_q;
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (pipe_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd_i;
            rf_wdata_d = pipe_data_i;
        end else if (hb_grant) begin
            // An MDU result to x0 still drains, it just produces no write.
            rf_we_d    = (hb_rd_q != 5'd0);
            rf_waddr_d = hb_rd_q;
            rf_wdata_d = hb_data_q;
            hb_valid_d = 1'b0;
        end

        if (hb_grant || !hb_valid_q) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (mdu_fire) begin
            hb_valid_d   = 1'b1;
            hb_rd_d      = mdu_rd_i;
            hb_data_d    = mdu_data_i;
            starve_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_valid_q   <= 1'b0;
            hb_rd_q      <= 5'd0;
            hb_data_q    <= 32'd0;
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
        end else begin
            hb_valid_q   <= hb_valid_d;
            hb_rd_q      <= hb_rd_d;
            hb_data_q    <= hb_data_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

endmodule
